pq_candidate_gen: RTL and testbench

- Writer end of the pq FIFO interface that the primality tester reads. Packs narrow words from the 2-LFSR RNG into NUM_BITS-wide candidates.
- Forces each candidate to be odd and full-width, and optionally rejects multiples of 3.
- Buffers accepted candidates in an internal first-word-fall-through FIFO. The tester pops candidates with pq_fifo_rd_en and samples pq_fifo_dout.

---
 rtl/pq_gen_pkg.sv | 28 ++
 rtl/pq_candidate_gen_if.sv | 34 +++
 rtl/pq_sync_fifo.sv | 66 ++++++
 rtl/pq_candidate_gen.sv | 118 +++++++++++
 tb/tb_pq_candidate_gen.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/pq_gen_pkg.sv
// Shared types and helpers for the pq candidate generator and its FIFO.
// Holds the FSM encoding, default geometry and the digit-sum mod-3 reduction.
package pq_gen_pkg;

  localparam int DEF_NUM_BITS  = 128;
  localparam int DEF_RNG_WIDTH = 32;
  localparam int WORDS         = DEF_NUM_BITS / DEF_RNG_WIDTH;
  localparam int REJ_W         = 16;
  localparam int MOD3_MAX_BITS = 512;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    CHECK,
    WRITE
  } state_e;

  // 4 == 1 (mod 3), so the sum of all 2-bit digits has the same residue as v.
  function automatic logic [1:0] mod3(input logic [MOD3_MAX_BITS-1:0] v);
    logic [10:0] sum;
    sum = '0;
    for (int i = 0; i < MOD3_MAX_BITS / 2; i++) begin
      sum = sum + 11'(v[2*i +: 2]);
    end
    return 2'(sum % 11'd3);
  endfunction

endpackage

// File: rtl/pq_candidate_gen_if.sv
// RNG input beats, enable, and pq FIFO read side of the candidate generator.
// master is the generator's view; slave is the RNG/tester side.
interface pq_candidate_gen_if
  import pq_gen_pkg::*;
#(
  parameter int NUM_BITS   = 128,
  parameter int RNG_WIDTH  = 32,
  parameter int FIFO_DEPTH = 4
);

  logic                          enable;
  logic                          rng_valid;
  logic [RNG_WIDTH-1:0]          rng_data;
  logic                          rng_ready;
  logic                          pq_fifo_rd_en;
  logic [NUM_BITS-1:0]           pq_fifo_dout;
  logic                          pq_fifo_empty;
  logic                          pq_fifo_full;
  logic [$clog2(FIFO_DEPTH):0]   pq_fifo_count;
  logic [REJ_W-1:0]              reject_count;

  modport master (
    input  enable, rng_valid, rng_data, pq_fifo_rd_en,
    output rng_ready, pq_fifo_dout, pq_fifo_empty, pq_fifo_full,
           pq_fifo_count, reject_count
  );

  modport slave (
    output enable, rng_valid, rng_data, pq_fifo_rd_en,
    input  rng_ready, pq_fifo_dout, pq_fifo_empty, pq_fifo_full,
           pq_fifo_count, reject_count
  );

endinterface

// File: rtl/pq_sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered empty/full/count.
// Pops on empty and pushes on full are ignored; the head reads as 0 while empty.
module pq_sync_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             empty_q, full_q;
  logic             push, pop;

  assign push = wr_en_i && !full_q;
  assign pop  = rd_en_i && !empty_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == CW'(DEPTH));
    end
  end

  // NOTE: storage is left unreset; the empty flag masks stale entries instead.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = empty_q ? '0 : mem[rd_ptr_q];
  assign empty_o   = empty_q;
  assign full_o    = full_q;
  assign count_o   = count_q;

endmodule

// File: rtl/pq_candidate_gen.sv
// Packs RNG beats (LS word first) into odd, full-width candidates, optionally
// drops multiples of 3, and queues survivors in an FWFT FIFO for the tester.
module pq_candidate_gen
  import pq_gen_pkg::*;
#(
  parameter int NUM_BITS    = 128,
  parameter int RNG_WIDTH   = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int FILTER_MOD3 = 1
) (
  input  logic              aclk,
  input  logic              areset,
  pq_candidate_gen_if.master bus
);

  localparam int N_WORDS = NUM_BITS / RNG_WIDTH;
  localparam int CNT_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_BITS-1:0] asm_q, asm_d;
  logic [NUM_BITS-1:0] cand_q, cand_d;
  logic [REJ_W-1:0]   rej_q, rej_d;
  logic [NUM_BITS-1:0] cand;
  logic               div3;
  logic               push;
  logic               fifo_full;

  always_comb begin
    cand               = asm_q;
    cand[NUM_BITS-1]   = 1'b1;
    cand[0]            = 1'b1;
  end

  assign div3 = (mod3(MOD3_MAX_BITS'(cand)) == 2'd0);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    cand_d  = cand_q;
    rej_d   = rej_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.enable) begin
          state_d = COLLECT;
          cnt_d   = '0;
        end
      end
      COLLECT: begin
        if (bus.rng_valid) begin
          asm_d[cnt_q*RNG_WIDTH +: RNG_WIDTH] = bus.rng_data;
          if (cnt_q == CNT_W'(N_WORDS - 1)) begin
            cnt_d   = '0;
            state_d = CHECK;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      CHECK: begin
        cand_d = cand;
        if (FILTER_MOD3 != 0 && div3) begin
          if (rej_q != '1) rej_d = rej_q + REJ_W'(1);
          state_d = bus.enable ? COLLECT : IDLE;
        end else begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        // Hold the candidate until the FIFO has room; it is never dropped.
        if (!fifo_full) begin
          push    = 1'b1;
          state_d = bus.enable ? COLLECT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      asm_q   <= '0;
      cand_q  <= '0;
      rej_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      cand_q  <= cand_d;
      rej_q   <= rej_d;
    end
  end

  assign bus.rng_ready    = (state_q == COLLECT);
  assign bus.reject_count = rej_q;
  assign bus.pq_fifo_full = fifo_full;

  pq_sync_fifo #(
    .WIDTH (NUM_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (aclk),
    .rst_i     (areset),
    .wr_en_i   (push),
    .wr_data_i (cand_q),
    .rd_en_i   (bus.pq_fifo_rd_en),
    .rd_data_o (bus.pq_fifo_dout),
    .empty_o   (bus.pq_fifo_empty),
    .full_o    (fifo_full),
    .count_o   (bus.pq_fifo_count)
  );

endmodule

// File: tb/tb_pq_candidate_gen.sv
// Directed bench for pq_candidate_gen: table of candidates with hand-computed
// results, then FIFO full/stall, empty-pop, push+pop and mid-candidate reset.
module tb_pq_candidate_gen;

  localparam int NB = 128;
  localparam int RW = 32;
  localparam int FD = 4;

  typedef struct packed {
    logic [NB-1:0] beats;   // beat k is beats[k*RW +: RW]
    logic          gap;     // insert a valid gap before every beat
    logic          accept;
    logic [NB-1:0] dout;
  } vec_t;

  logic aclk = 1'b0;
  logic areset;
  int   checks = 0;
  int   failures = 0;
  int   exp_rej = 0;
  vec_t vecs [9];

  always #5 aclk = ~aclk;

  pq_candidate_gen_if #(.NUM_BITS(NB), .RNG_WIDTH(RW), .FIFO_DEPTH(FD)) bus ();

  pq_candidate_gen #(
    .NUM_BITS(NB), .RNG_WIDTH(RW), .FIFO_DEPTH(FD), .FILTER_MOD3(1)
  ) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Offers one beat and returns 1 ns after the edge that accepted it.
  task automatic send_beat(input logic [RW-1:0] d, input logic gap);
    logic acc;
    int   n;
    if (gap) begin
      bus.rng_valid = 1'b0;
      tick();
    end
    bus.rng_valid = 1'b1;
    bus.rng_data  = d;
    n = 0;
    forever begin
      @(negedge aclk);
      acc = bus.rng_ready;
      tick();
      if (acc) break;
      n++;
      if (n > 200) begin
        check("beat_timeout", NB'(0), NB'(1));
        break;
      end
    end
    bus.rng_valid = 1'b0;
  endtask

  task automatic send_cand(input logic [NB-1:0] v, input logic gap);
    for (int k = 0; k < NB / RW; k++) send_beat(v[k*RW +: RW], gap);
  endtask

  task automatic pop_one();
    bus.pq_fifo_rd_en = 1'b1;
    tick();
    bus.pq_fifo_rd_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_empty"}, NB'(bus.pq_fifo_empty), NB'(1));
    check({tag, "_full"},  NB'(bus.pq_fifo_full),  NB'(0));
    check({tag, "_count"}, NB'(bus.pq_fifo_count), NB'(0));
    check({tag, "_dout"},  bus.pq_fifo_dout,       NB'(0));
    check({tag, "_rej"},   NB'(bus.reject_count),  NB'(0));
    check({tag, "_ready"}, NB'(bus.rng_ready),     NB'(0));
  endtask

  logic [NB-1:0] c [5];

  initial begin
    vecs[0] = '{beats: '0, gap: 0, accept: 0, dout: '0};
    vecs[1] = '{beats: 128'h2, gap: 0, accept: 1,
                dout: 128'h80000000_00000000_00000000_00000003};
    vecs[2] = '{beats: 128'h44444444_33333333_22222222_11111111, gap: 1, accept: 1,
                dout: 128'hC4444444_33333333_22222222_11111111};
    vecs[3] = '{beats: 128'h1, gap: 0, accept: 0, dout: '0};
    vecs[4] = '{beats: 128'h4, gap: 1, accept: 1,
                dout: 128'h80000000_00000000_00000000_00000005};
    vecs[5] = '{beats: '1, gap: 0, accept: 0, dout: '0};
    vecs[6] = '{beats: 128'h80000000_00000000_00000000_00000006, gap: 0, accept: 0, dout: '0};
    vecs[7] = '{beats: 128'hAAAAAAAA, gap: 0, accept: 1,
                dout: 128'h80000000_00000000_00000000_AAAAAAAB};
    vecs[8] = '{beats: 128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE, gap: 1, accept: 0, dout: '0};

    areset            = 1'b1;
    bus.enable        = 1'b0;
    bus.rng_valid     = 1'b0;
    bus.rng_data      = '0;
    bus.pq_fifo_rd_en = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    areset = 1'b0;
    bus.enable = 1'b1;

    for (int i = 0; i < 9; i++) begin
      send_cand(vecs[i].beats, vecs[i].gap);
      tick();
      if (!vecs[i].accept) exp_rej++;
      check($sformatf("v%0d_rej", i), NB'(bus.reject_count), NB'(exp_rej));
      check($sformatf("v%0d_empty_n2", i), NB'(bus.pq_fifo_empty), NB'(1));
      tick();
      check($sformatf("v%0d_empty_n3", i), NB'(bus.pq_fifo_empty), NB'(!vecs[i].accept));
      if (vecs[i].accept) begin
        check($sformatf("v%0d_dout", i), bus.pq_fifo_dout, vecs[i].dout);
        pop_one();
        check($sformatf("v%0d_empty_pop", i), NB'(bus.pq_fifo_empty), NB'(1));
      end
    end

    // Fill to full, stall the fifth candidate in WRITE, then release it.
    c[0] = vecs[1].dout; c[1] = vecs[2].dout; c[2] = vecs[4].dout;
    c[3] = vecs[7].dout; c[4] = 128'h80000000_00000000_00000000_00000009;
    send_cand(vecs[1].beats, 0);
    send_cand(vecs[2].beats, 0);
    send_cand(vecs[4].beats, 0);
    send_cand(vecs[7].beats, 0);
    send_cand(128'h8, 0);
    repeat (5) tick();
    check("stall_count", NB'(bus.pq_fifo_count), NB'(4));
    check("stall_full",  NB'(bus.pq_fifo_full),  NB'(1));
    check("stall_ready", NB'(bus.rng_ready),     NB'(0));
    check("stall_head",  bus.pq_fifo_dout,       c[0]);
    pop_one();
    check("release_count_p", NB'(bus.pq_fifo_count), NB'(3));
    check("release_full_p",  NB'(bus.pq_fifo_full),  NB'(0));
    tick();
    check("release_count_p1", NB'(bus.pq_fifo_count), NB'(4));
    check("release_full_p1",  NB'(bus.pq_fifo_full),  NB'(1));
    for (int i = 1; i < 5; i++) begin
      check($sformatf("drain%0d", i), bus.pq_fifo_dout, c[i]);
      pop_one();
    end
    check("drained_empty", NB'(bus.pq_fifo_empty), NB'(1));
    check("rej_after_fill", NB'(bus.reject_count), NB'(exp_rej));

    // Pops on an empty FIFO are ignored.
    bus.pq_fifo_rd_en = 1'b1;
    repeat (3) tick();
    bus.pq_fifo_rd_en = 1'b0;
    check("emptypop_count", NB'(bus.pq_fifo_count), NB'(0));
    check("emptypop_empty", NB'(bus.pq_fifo_empty), NB'(1));

    // Push and pop in the same cycle at count 2.
    send_cand(vecs[1].beats, 0);
    send_cand(vecs[2].beats, 0);
    repeat (3) tick();
    check("pp_count_before", NB'(bus.pq_fifo_count), NB'(2));
    send_cand(vecs[4].beats, 0);
    tick();
    bus.pq_fifo_rd_en = 1'b1;
    tick();
    bus.pq_fifo_rd_en = 1'b0;
    check("pp_count", NB'(bus.pq_fifo_count), NB'(2));
    check("pp_head",  bus.pq_fifo_dout,       vecs[2].dout);
    pop_one();

    // Reset after two beats with two entries queued.
    check("rst_pre_count", NB'(bus.pq_fifo_count), NB'(1));
    send_cand(vecs[7].beats, 0);
    repeat (3) tick();
    check("rst_pre_count2", NB'(bus.pq_fifo_count), NB'(2));
    send_beat(32'hDEADBEEF, 0);
    send_beat(32'hCAFEF00D, 0);
    areset = 1'b1;
    tick();
    check_reset_outputs("midrst");
    areset = 1'b0;
    exp_rej = 0;
    send_cand(vecs[2].beats, 0);
    tick();
    tick();
    check("fresh_empty", NB'(bus.pq_fifo_empty), NB'(0));
    check("fresh_dout",  bus.pq_fifo_dout,       vecs[2].dout);
    check("fresh_count", NB'(bus.pq_fifo_count), NB'(1));
    check("fresh_rej",   NB'(bus.reject_count),  NB'(exp_rej));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
